// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 scan generator and the
// drawing blocks that consume scan_x/scan_y. Derived totals and sync
// boundaries are computed here so every consumer agrees on screen bounds.
package vga_pkg;

    // Counter and coordinate widths
    localparam int CNT_W = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [X_W-1:0]   scan_x_t;
    typedef logic [Y_W-1:0]   scan_y_t;

    // Default timing: 100 MHz system clock, 25 MHz pixel rate
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // Total number of counts in one period (pixels per line or lines per frame)
    function automatic int scan_total(input int visible, input int fp,
                                      input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    // First count at which the sync pulse is active
    function automatic int sync_begin(input int visible, input int fp);
        return visible + fp;
    endfunction

    localparam int H_TOTAL      = scan_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL      = scan_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int H_SYNC_START = sync_begin(DEF_H_VISIBLE, DEF_H_FP);
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = sync_begin(DEF_V_VISIBLE, DEF_V_FP);
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate tick divider. tick_due is the combinational strobe the scan
// counters advance on; pix_tick is its registered copy, so the pulse seen
// outside rises on the very edge the counters and sync outputs change.
module pix_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
)(
    input  logic clk,
    input  logic rst_n,
    output logic tick_due,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // A stray count above the terminal value also counts as due, so it wraps
    assign tick_due = (div_cnt >= DIV_LAST);

    // Count 0..CLK_DIV-1 and register the one-clk tick pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else begin
            if (tick_due) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            pix_tick <= tick_due;
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator. Produces the horizontal/vertical counters, the
// active-low sync pulses, the visible-area flag and the scan coordinates used
// by the drawing blocks. Every output is registered from the next-state
// counter values so they all change on the same clk edge with zero skew.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
)(
    input  logic            clk,
    input  logic            rst_n,
    output logic            pix_tick,
    output logic            hsync,
    output logic            vsync,
    output logic            video_on,
    output logic [X_W-1:0]  scan_x,
    output logic [Y_W-1:0]  scan_y,
    output logic            frame_start
);

    localparam cnt_t H_LAST = cnt_t'(scan_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
    localparam cnt_t V_LAST = cnt_t'(scan_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
    localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
    localparam cnt_t H_SS   = cnt_t'(sync_begin(H_VISIBLE, H_FP));
    localparam cnt_t H_SE   = cnt_t'(sync_begin(H_VISIBLE, H_FP) + H_SYNC);
    localparam cnt_t V_SS   = cnt_t'(sync_begin(V_VISIBLE, V_FP));
    localparam cnt_t V_SE   = cnt_t'(sync_begin(V_VISIBLE, V_FP) + V_SYNC);

    logic tick_due;
    logic h_wrap;
    logic v_wrap;
    cnt_t h_cnt;
    cnt_t v_cnt;
    cnt_t h_next;
    cnt_t v_next;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_due (tick_due),
        .pix_tick (pix_tick)
    );

    // Next counter values; out-of-range states are treated as terminal so they wrap to 0
    always_comb begin
        h_wrap = (h_cnt >= H_LAST);
        v_wrap = (v_cnt >= V_LAST);
        h_next = h_wrap ? '0 : h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    // Advance the raster counters once per pixel tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick_due) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Register syncs, visible flag and coordinates from the next counter values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
            scan_x   <= '0;
            scan_y   <= '0;
        end else if (tick_due) begin
            hsync    <= !((h_next >= H_SS) && (h_next < H_SE));
            vsync    <= !((v_next >= V_SS) && (v_next < V_SE));
            video_on <= (h_next < H_VIS) && (v_next < V_VIS);
            scan_x   <= h_next;
            scan_y   <= (v_next < V_VIS) ? v_next[Y_W-1:0] : '0;
        end
    end

    // One-clk pulse on the tick that wraps the raster back to the origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick_due && h_wrap && v_wrap;
        end
    end

endmodule
